// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types for the pipeline hazard controller.
// Controller states and EX operand forward-select encodings.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM result is younger than WB, so it wins; $0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0 && mem_we && mem_rd == src) begin
            sel = FWD_MEM;
        end else if (src != 5'd0 && wb_we && wb_rd == src) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// forward_unit: EX operand bypass selection.
// Purely combinational; picks MEM, WB or register file per operand.
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_num_write,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_num_write,
    input  logic       wb_reg_write,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    // Select the youngest in-flight producer for each EX source.
    always_comb begin
        forward_a = fwd_sel(ex_rs, mem_reg_write, mem_num_write,
                            wb_reg_write, wb_num_write);
        forward_b = fwd_sel(ex_rt, mem_reg_write, mem_num_write,
                            wb_reg_write, wb_num_write);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline enable/flush and forwarding control.
// Handles load-use, taken branches, data-memory waits and timeout trap.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_num_write,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_num_write,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_num_write,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_q, err_d;
    logic              run_ctl;
    logic              load_use;
    logic [1:0]        fu_a, fu_b;

    forward_unit u_fwd (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_num_write (mem_num_write),
        .mem_reg_write (mem_reg_write),
        .wb_num_write  (wb_num_write),
        .wb_reg_write  (wb_reg_write),
        .forward_a     (fu_a),
        .forward_b     (fu_b)
    );

    // Loads have no value until MEM; a dependent ID instruction must wait.
    // ex_reg_write is implied for loads, so only the destination matters.
    always_comb begin
        load_use = ex_mem_read && (ex_num_write != 5'd0) &&
                   ((id_uses_rs && id_rs == ex_num_write) ||
                    (id_uses_rt && id_rt == ex_num_write));
    end

    // Next state, wait counter and per-stage enable/flush decode.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        err_d        = err_q;
        wait_inc     = wait_q + WAIT_W'(1);
        run_ctl      = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
            wait_d       = '0;
            err_d        = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                        state_d      = MEM_WAIT;
                        wait_d       = '0;
                    end else begin
                        run_ctl = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_d = RUN;
                        wait_d  = '0;
                        run_ctl = 1'b1;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                        wait_d       = wait_inc;
                        if (wait_inc == WAIT_W'(TIMEOUT)) begin
                            state_d = TRAP;
                            err_d   = 1'b1;
                        end
                    end
                end
                TRAP: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                    err_d        = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase
            if (run_ctl) begin
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    // Saturating count of cycles in which fetch did not advance.
    always_comb begin
        stall_d = stall_q;
        if (reset) begin
            stall_d = '0;
        end else if (!pc_en && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Registered controller state.
    always_ff @(posedge clock) begin
        state_q <= state_d;
        wait_q  <= wait_d;
        stall_q <= stall_d;
        err_q   <= err_d;
    end

    // Reset forces register-file operands and hides the stale trap flag.
    always_comb begin
        forward_a    = reset ? FWD_RF : fu_a;
        forward_b    = reset ? FWD_RF : fu_b;
        mem_error    = err_q && !reset;
        stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
// TIMEOUT=4 and a 4-bit stall counter so saturation is reachable.
module tb_hazard_ctrl;

    localparam logic [8:0] P_RUN = 9'b11111_0000;
    localparam logic [8:0] P_RST = 9'b11111_1111;
    localparam logic [8:0] P_BR  = 9'b11111_1100;
    localparam logic [8:0] P_LU  = 9'b00111_0100;
    localparam logic [8:0] P_FRZ = 9'b00001_0001;
    localparam logic [8:0] P_TRP = 9'b00000_0001;

    typedef struct {
        logic [8:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] stall;
        logic       err;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic       id_uses_rs, id_uses_rt;
    logic [4:0] ex_num_write, mem_num_write, wb_num_write;
    logic       ex_reg_write, ex_mem_read, ex_branch_taken;
    logic       mem_reg_write, wb_reg_write, mem_req, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] forward_a, forward_b;
    logic       mem_error;
    logic [3:0] stall_cycles;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] exp_stall = 4'd0;
    logic       exp_err = 1'b0;

    always #5 clock = ~clock;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_num_write    (ex_num_write),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_num_write   (mem_num_write),
        .mem_reg_write   (mem_reg_write),
        .wb_num_write    (wb_num_write),
        .wb_reg_write    (wb_reg_write),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_num_write = 0; ex_reg_write = 0;
        ex_mem_read = 0; ex_branch_taken = 0;
        mem_num_write = 0; mem_reg_write = 0;
        wb_num_write = 0; wb_reg_write = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // Push expectation, compare at negedge, then advance the model past the edge.
    task automatic step(input string tag, input logic [8:0] pat,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.ctl = pat;
        e.fa = fa;
        e.fb = fb;
        e.stall = exp_stall;
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clock);
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "/ctl"}, {23'd0, pc_en, if_id_en, id_ex_en,
                ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                ex_mem_flush, mem_wb_flush}, {23'd0, e.ctl});
            chk({tag, "/fwd_a"}, {30'd0, forward_a}, {30'd0, e.fa});
            chk({tag, "/fwd_b"}, {30'd0, forward_b}, {30'd0, e.fb});
            chk({tag, "/stall"}, {28'd0, stall_cycles}, {28'd0, e.stall});
            chk({tag, "/err"}, {31'd0, mem_error}, {31'd0, e.err});
        end
        @(posedge clock);
        if (reset) begin
            exp_stall = 4'd0;
        end else if (!e.ctl[8] && exp_stall != 4'hF) begin
            exp_stall = exp_stall + 4'd1;
        end
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        ex_rs = 5'd3; mem_reg_write = 1'b1; mem_num_write = 5'd3;
        step("reset", P_RST, 2'b00, 2'b00);
        reset = 1'b0;

        clr();
        ex_rs = 5'd3; ex_rt = 5'd7;
        mem_reg_write = 1; mem_num_write = 5'd3;
        wb_reg_write = 1; wb_num_write = 5'd7;
        step("fwd_mem_wb", P_RUN, 2'b10, 2'b01);
        clr();
        ex_rs = 5'd3; ex_rt = 5'd4;
        wb_reg_write = 1; wb_num_write = 5'd3;
        step("fwd_wb_only", P_RUN, 2'b01, 2'b00);
        clr();
        mem_reg_write = 1; wb_reg_write = 1;
        step("fwd_r0", P_RUN, 2'b00, 2'b00);
        clr();
        ex_rs = 5'd9; ex_rt = 5'd9;
        mem_reg_write = 1; mem_num_write = 5'd9;
        wb_reg_write = 1; wb_num_write = 5'd9;
        step("fwd_mem_beats_wb", P_RUN, 2'b10, 2'b10);
        clr();
        ex_rs = 5'd9; mem_num_write = 5'd9; wb_num_write = 5'd9;
        step("fwd_no_we", P_RUN, 2'b00, 2'b00);

        clr();
        ex_mem_read = 1; ex_reg_write = 1; ex_num_write = 5'd5;
        id_rt = 5'd5; id_uses_rt = 1;
        step("load_use_rt", P_LU, 2'b00, 2'b00);
        clr();
        step("after_lu", P_RUN, 2'b00, 2'b00);
        ex_mem_read = 1; ex_reg_write = 1; ex_num_write = 5'd5;
        id_rt = 5'd5; id_uses_rt = 0;
        step("lu_unused_rt", P_RUN, 2'b00, 2'b00);
        clr();
        ex_mem_read = 1; id_uses_rs = 1;
        step("lu_r0", P_RUN, 2'b00, 2'b00);
        clr();
        ex_mem_read = 1; ex_num_write = 5'd6;
        id_rs = 5'd6; id_uses_rs = 1; ex_branch_taken = 1;
        step("branch_wins", P_BR, 2'b00, 2'b00);

        clr();
        mem_req = 1; mem_ready = 0;
        step("mw_entry", P_FRZ, 2'b00, 2'b00);
        step("mw_wait1", P_FRZ, 2'b00, 2'b00);
        ex_branch_taken = 1;
        step("mw_br_ignored", P_FRZ, 2'b00, 2'b00);
        mem_ready = 1;
        step("mw_release_br", P_BR, 2'b00, 2'b00);
        clr();
        step("mw_back_run", P_RUN, 2'b00, 2'b00);
        mem_req = 1; mem_ready = 1;
        step("mw_zero_stall", P_RUN, 2'b00, 2'b00);

        clr();
        mem_req = 1;
        step("rst_mw_entry", P_FRZ, 2'b00, 2'b00);
        step("rst_mw_wait", P_FRZ, 2'b00, 2'b00);
        reset = 1'b1;
        step("rst_mid_wait", P_RST, 2'b00, 2'b00);
        reset = 1'b0;
        clr();
        step("rst_after", P_RUN, 2'b00, 2'b00);

        mem_req = 1; mem_ready = 0;
        step("to_entry", P_FRZ, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step("to_wait", P_FRZ, 2'b00, 2'b00);
        end
        exp_err = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) mem_ready = 1;
            step("trap", P_TRP, 2'b00, 2'b00);
        end
        reset = 1'b1;
        exp_err = 1'b0;
        step("trap_reset", P_RST, 2'b00, 2'b00);
        reset = 1'b0;
        clr();
        step("trap_cleared", P_RUN, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline controller for the 5-stage MIPS core: decides, every cycle, which pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) load, hold or take a bubble, and drives the EX-stage operand forwarding selects. It handles load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a timeout that traps the pipeline. It sits beside the stage registers and feeds their enable and flush pins.

## Interface
- TIMEOUT, 16: maximum MEM_WAIT cycles before trapping (≥1).
- CNT_W, 16: width of the stall-cycle counter.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs / rt.
- ex_rs, ex_rt  in  5 each  source register numbers of the instruction in EX.
- ex_num_write, ex_reg_write, ex_mem_read  in  5/1/1  EX destination, write-enable, is-load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_num_write, mem_reg_write  in  5/1  MEM destination and write-enable.
- wb_num_write, wb_reg_write  in  5/1  WB destination and write-enable.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register loads at the next edge.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  stage register loads zero (bubble); dominates its _en.
- forward_a, forward_b  out  2 each  EX operand source: 00 register file, 01 WB value, 10 MEM value.
- mem_error  out  1  sticky timeout trap.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- States: RUN, MEM_WAIT, TRAP. Reset → RUN, wait counter 0, stall_cycles 0, mem_error 0.
- While reset high: all _en=1, all _flush=1, forward_a/b=00, mem_error=0, so every stage register clears.
- RUN, priority high→low:
  - mem_req & !mem_ready: go MEM_WAIT; this cycle pc/if_id/id_ex/ex_mem _en=0, mem_wb_flush=1.
  - ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1 (redirect).
  - Load-use: ex_mem_read & ex_num_write≠0 & ((id_uses_rs & id_rs==ex_num_write) | (id_uses_rt & id_rt==ex_num_write)): pc_en=0, if_id_en=0, id_ex_flush=1.
  - Otherwise all _en=1, all _flush=0.
- MEM_WAIT: same freeze as entry; wait counter increments each cycle. mem_ready=1 → RUN, counter 0, and that cycle behaves as RUN with the memory condition cleared (pipeline advances). Counter reaching TIMEOUT with mem_ready=0 → TRAP.
- TRAP: all _en=0, mem_wb_flush=1, mem_error=1; exit only by reset.
- Branch or load-use while frozen: ignored; EX and ID contents are held, so they are acted on in the release cycle.
- Forwarding (per operand, shown for rs): ex_rs≠0 & mem_reg_write & mem_num_write==ex_rs → 10; else ex_rs≠0 & wb_reg_write & wb_num_write==ex_rs → 01; else 00. MEM beats WB. $0 never forwarded.
- stall_cycles increments on every cycle with pc_en=0 (load-use, MEM_WAIT, TRAP); saturates at all-ones.

## Timing
- Enables, flushes, forward selects: combinational from state and inputs, same cycle.
- State, wait counter, stall_cycles, mem_error: registered; mem_error rises the cycle after the TIMEOUT-th wait cycle.
- mem_req & mem_ready in the same cycle: zero stall.
- Load-use costs exactly one bubble; taken branch costs two squashed slots.
- Max MEM_WAIT duration: TIMEOUT cycles; total freeze including entry cycle: TIMEOUT+1.

## Structure
- Shared package: state enum (RUN, MEM_WAIT, TRAP), forward-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
- One sub-module: forward_unit (purely combinational rs/rt select logic), instantiated once, both operands inside.

## Test plan
- Back-to-back dependence: add $3 in MEM, sub reading $3 in EX → forward_a=10; same with $3 only in WB → 01; dest $0 → 00.
- lw $5 in EX, ID reads $5 with id_uses_rt=1 → one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles +1.
- ex_branch_taken=1 together with load-use → if_id_flush=1, id_ex_flush=1, pc_en=1 (branch wins).
- mem_req=1, mem_ready low 3 cycles then high → 3 frozen cycles with mem_wb_flush=1, release on 4th, state back to RUN.
- mem_ready held low, TIMEOUT=4 → TRAP, mem_error=1 after 4 wait cycles, stays until reset; reset clears it and stall_cycles.
- Reset asserted mid-MEM_WAIT → next cycle RUN, all registers cleared, counters 0.
